// File: rtl/riscv_id_stage.sv
// RV32IM instruction-decode stage: register file, control decoder
// and immediate generator, all driven from one instruction word.
module riscv_id_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] WB_DATA,
    input  logic [4:0]  WB_ADDRESS,
    input  logic        WB_WRITE,
    output logic [31:0] OUT1,
    output logic [31:0] OUT2,
    output logic [31:0] U_TYPE,
    output logic [31:0] J_TYPE,
    output logic [31:0] I_TYPE,
    output logic [31:0] S_TYPE,
    output logic [31:0] B_TYPE,
    output logic [4:0]  ALUOP,
    output logic [2:0]  MUXIMMTYPE_SELECT,
    output logic        MUXPC_SELECT,
    output logic        MUXIMM_SELECT,
    output logic        MUXJAL_SELECT,
    output logic        MUXDATAMEM_SELECT,
    output logic        WRITE_ENABLE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BRANCH,
    output logic        JUMP
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b01000;
    localparam logic [4:0] ALU_FWD = 5'b11111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_shift_imm;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];
    assign rs1    = INSTRUCTION[19:15];
    assign rs2    = INSTRUCTION[24:20];

    assign is_shift_imm = (opcode == OP_IALU) &&
                          ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Next register-file contents: one write port, x0 is never written.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (WB_WRITE && (WB_ADDRESS != 5'd0)) begin
            regs_d[WB_ADDRESS] = WB_DATA;
        end
    end

    // Register-file state; reset clears every entry and wins over a write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational reads with x0 hard-wired to zero, no write bypass.
    always_comb begin
        OUT1 = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
        OUT2 = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    end

    // Immediate generation; shift-immediates carry only a 5-bit shamt.
    always_comb begin
        U_TYPE = {INSTRUCTION[31:12], 12'b0};
        if (is_shift_imm) begin
            I_TYPE = {27'b0, INSTRUCTION[24:20]};
        end else begin
            I_TYPE = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
        end
        S_TYPE = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25],
                  INSTRUCTION[11:7]};
        B_TYPE = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                  INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
        J_TYPE = {{11{INSTRUCTION[31]}}, INSTRUCTION[31],
                  INSTRUCTION[19:12], INSTRUCTION[20],
                  INSTRUCTION[30:21], 1'b0};
    end

    // Main control decoder; unknown opcodes fall through as a NOP.
    always_comb begin
        ALUOP             = ALU_ADD;
        MUXIMMTYPE_SELECT = IMM_I;
        MUXPC_SELECT      = 1'b0;
        MUXIMM_SELECT     = 1'b0;
        MUXJAL_SELECT     = 1'b0;
        MUXDATAMEM_SELECT = 1'b0;
        WRITE_ENABLE      = 1'b0;
        MEM_READ          = 1'b0;
        MEM_WRITE         = 1'b0;
        BRANCH            = 1'b0;
        JUMP              = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000001) begin
                    ALUOP = {2'b10, funct3};
                end else begin
                    ALUOP = {1'b0, INSTRUCTION[30], funct3};
                end
                WRITE_ENABLE = 1'b1;
            end
            OP_IALU: begin
                if (funct3 == 3'b101) begin
                    ALUOP = {1'b0, INSTRUCTION[30], funct3};
                end else begin
                    ALUOP = {2'b00, funct3};
                end
                WRITE_ENABLE  = 1'b1;
                MUXIMM_SELECT = 1'b1;
            end
            OP_LOAD: begin
                WRITE_ENABLE      = 1'b1;
                MEM_READ          = 1'b1;
                MUXDATAMEM_SELECT = 1'b1;
                MUXIMM_SELECT     = 1'b1;
            end
            OP_STORE: begin
                MEM_WRITE         = 1'b1;
                MUXIMM_SELECT     = 1'b1;
                MUXIMMTYPE_SELECT = IMM_S;
            end
            OP_BRANCH: begin
                ALUOP             = ALU_SUB;
                BRANCH            = 1'b1;
                MUXIMMTYPE_SELECT = IMM_B;
            end
            OP_LUI: begin
                ALUOP             = ALU_FWD;
                WRITE_ENABLE      = 1'b1;
                MUXIMM_SELECT     = 1'b1;
                MUXIMMTYPE_SELECT = IMM_U;
            end
            OP_AUIPC: begin
                MUXPC_SELECT      = 1'b1;
                WRITE_ENABLE      = 1'b1;
                MUXIMM_SELECT     = 1'b1;
                MUXIMMTYPE_SELECT = IMM_U;
            end
            OP_JAL: begin
                JUMP              = 1'b1;
                MUXJAL_SELECT     = 1'b1;
                WRITE_ENABLE      = 1'b1;
                MUXPC_SELECT      = 1'b1;
                MUXIMM_SELECT     = 1'b1;
                MUXIMMTYPE_SELECT = IMM_J;
            end
            OP_JALR: begin
                JUMP          = 1'b1;
                MUXJAL_SELECT = 1'b1;
                WRITE_ENABLE  = 1'b1;
                MUXIMM_SELECT = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_id_stage.sv
// Scoreboard bench for riscv_id_stage: directed instructions and
// register-file traffic, expected values hand-computed in the tables.
module tb_riscv_id_stage;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [31:0] WB_DATA;
    logic [4:0]  WB_ADDRESS;
    logic        WB_WRITE;
    logic [31:0] OUT1, OUT2;
    logic [31:0] U_TYPE, J_TYPE, I_TYPE, S_TYPE, B_TYPE;
    logic [4:0]  ALUOP;
    logic [2:0]  MUXIMMTYPE_SELECT;
    logic        MUXPC_SELECT, MUXIMM_SELECT, MUXJAL_SELECT;
    logic        MUXDATAMEM_SELECT, WRITE_ENABLE, MEM_READ;
    logic        MEM_WRITE, BRANCH, JUMP;

    riscv_id_stage dut (
        .CLK(CLK),
        .RESET(RESET),
        .INSTRUCTION(INSTRUCTION),
        .WB_DATA(WB_DATA),
        .WB_ADDRESS(WB_ADDRESS),
        .WB_WRITE(WB_WRITE),
        .OUT1(OUT1),
        .OUT2(OUT2),
        .U_TYPE(U_TYPE),
        .J_TYPE(J_TYPE),
        .I_TYPE(I_TYPE),
        .S_TYPE(S_TYPE),
        .B_TYPE(B_TYPE),
        .ALUOP(ALUOP),
        .MUXIMMTYPE_SELECT(MUXIMMTYPE_SELECT),
        .MUXPC_SELECT(MUXPC_SELECT),
        .MUXIMM_SELECT(MUXIMM_SELECT),
        .MUXJAL_SELECT(MUXJAL_SELECT),
        .MUXDATAMEM_SELECT(MUXDATAMEM_SELECT),
        .WRITE_ENABLE(WRITE_ENABLE),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .BRANCH(BRANCH),
        .JUMP(JUMP)
    );

    // kinds: 0 OUT1, 1 OUT2, 2 U, 3 J, 4 I, 5 S, 6 B, 7 ALUOP, 8 T, 9 CTRL
    // CTRL bits: [8]PC [7]IMM [6]JAL [5]DATAMEM [4]WE [3]MR [2]MW [1]BR [0]JUMP
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   total = 0;
    int   bad = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0: return OUT1;
            1: return OUT2;
            2: return U_TYPE;
            3: return J_TYPE;
            4: return I_TYPE;
            5: return S_TYPE;
            6: return B_TYPE;
            7: return {27'd0, ALUOP};
            8: return {29'd0, MUXIMMTYPE_SELECT};
            default: return {23'd0, MUXPC_SELECT, MUXIMM_SELECT,
                             MUXJAL_SELECT, MUXDATAMEM_SELECT,
                             WRITE_ENABLE, MEM_READ, MEM_WRITE,
                             BRANCH, JUMP};
        endcase
    endfunction

    // Monitor: drain every pending expectation when a sample is presented.
    initial begin
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] a;
                e = q.pop_front();
                a = actual(e.kind);
                total++;
                if (a !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic present();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic decode(input string n, input logic [31:0] ins,
                          input logic [4:0] alu, input logic [2:0] t,
                          input logic [8:0] ctrl);
        INSTRUCTION = ins;
        expect_val({n, "_aluop"}, 7, {27'd0, alu});
        expect_val({n, "_immsel"}, 8, {29'd0, t});
        expect_val({n, "_ctrl"}, 9, {23'd0, ctrl});
    endtask

    initial begin
        RESET = 1'b0;
        INSTRUCTION = 32'h0000_0000;
        WB_DATA = '0;
        WB_ADDRESS = '0;
        WB_WRITE = 1'b0;
        #2;
        // Async reset without any clock edge; rs1=5, rs2=31, opcode 0.
        RESET = 1'b1;
        INSTRUCTION = 32'h01F2_8000;
        expect_val("rst_out1", 0, 32'h0);
        expect_val("rst_out2", 1, 32'h0);
        expect_val("rst_ctrl", 9, 32'h0);
        present();
        // Write attempt held off by reset.
        WB_ADDRESS = 5'd5;
        WB_DATA = 32'hDEAD_BEEF;
        WB_WRITE = 1'b1;
        @(posedge CLK);
        expect_val("rst_blocks_write", 0, 32'h0);
        present();
        @(negedge CLK);
        RESET = 1'b0;
        WB_DATA = 32'h1234_5678;
        expect_val("no_bypass_before", 0, 32'h0);
        present();
        @(posedge CLK);
        expect_val("write_x5_after", 0, 32'h1234_5678);
        present();
        @(negedge CLK);
        WB_ADDRESS = 5'd31;
        WB_DATA = 32'hA5A5_A5A5;
        @(posedge CLK);
        expect_val("write_x31", 1, 32'hA5A5_A5A5);
        expect_val("x5_kept", 0, 32'h1234_5678);
        present();
        @(negedge CLK);
        WB_ADDRESS = 5'd0;
        WB_DATA = 32'hFFFF_FFFF;
        @(posedge CLK);
        @(negedge CLK);
        WB_WRITE = 1'b0;
        INSTRUCTION = 32'h0000_0000;
        expect_val("x0_rs1", 0, 32'h0);
        expect_val("x0_rs2", 1, 32'h0);
        present();
        // Reset asserted while a write to x5 is pending.
        INSTRUCTION = 32'h01F2_8000;
        WB_ADDRESS = 5'd5;
        WB_DATA = 32'h7777_7777;
        WB_WRITE = 1'b1;
        RESET = 1'b1;
        @(posedge CLK);
        expect_val("rst_mid_write", 0, 32'h0);
        expect_val("rst_clears_x31", 1, 32'h0);
        present();
        @(negedge CLK);
        RESET = 1'b0;
        WB_WRITE = 1'b0;

        decode("addi", 32'hFFF0_0093, 5'b00000, 3'b000, 9'h090);
        expect_val("addi_imm", 4, 32'hFFFF_FFFF);
        present();
        decode("addi_bit30", 32'h4000_0093, 5'b00000, 3'b000, 9'h090);
        expect_val("addi_bit30_imm", 4, 32'h0000_0400);
        present();
        decode("lui", 32'h0000_1537, 5'b11111, 3'b011, 9'h090);
        expect_val("lui_imm", 2, 32'h0000_1000);
        present();
        decode("auipc", 32'h0000_1517, 5'b00000, 3'b011, 9'h190);
        present();
        decode("beq", 32'hFE20_8EE3, 5'b01000, 3'b010, 9'h002);
        expect_val("beq_imm", 6, 32'hFFFF_FFFC);
        present();
        decode("sw", 32'h0020_A423, 5'b00000, 3'b001, 9'h084);
        expect_val("sw_imm", 5, 32'h0000_0008);
        present();
        decode("lw", 32'h0041_2083, 5'b00000, 3'b000, 9'h0B8);
        expect_val("lw_imm", 4, 32'h0000_0004);
        present();
        decode("sub", 32'h4020_8033, 5'b01000, 3'b000, 9'h010);
        present();
        decode("sra", 32'h4020_D033, 5'b01101, 3'b000, 9'h010);
        present();
        decode("mul", 32'h0220_8033, 5'b10000, 3'b000, 9'h010);
        present();
        decode("srai", 32'h4030_D093, 5'b01101, 3'b000, 9'h090);
        expect_val("srai_imm", 4, 32'h0000_0003);
        present();
        decode("jal", 32'h0080_006F, 5'b00000, 3'b100, 9'h1D1);
        expect_val("jal_imm", 3, 32'h0000_0008);
        present();
        decode("jal_neg", 32'hFFDF_F06F, 5'b00000, 3'b100, 9'h1D1);
        expect_val("jal_neg_imm", 3, 32'hFFFF_FFFC);
        present();
        decode("jalr", 32'h0000_80E7, 5'b00000, 3'b000, 9'h0D1);
        present();
        decode("unknown", 32'hFFFF_FFFF, 5'b00000, 3'b000, 9'h000);
        present();

        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
